board_mem_responder: RTL and testbench

- Avalon-MM slave that models on-chip board memory.
- It is the responder for the SDRAM-facing master port of the piece move-generator accelerators (source board reads, generated-board writes).
- It stands in for SDRAM in simulation and can serve as a real on-chip scratch store on the DE1.
- It applies a programmable waitrequest stall and a fixed pipelined read latency, so that master handshakes are exercised the way real memory exercises them.

---
 rtl/board_mem_pkg.sv | 28 ++
 rtl/board_mem_rd_pipe.sv | 42 ++++
 rtl/board_mem_responder.sv | 144 ++++++++++++++
 tb/tb_board_mem_responder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : board_mem_pkg
//  Description : Shared types and constants for the board memory responder
//                and the move-generator masters that talk to it.
//  Revision    : 1.0 - initial release
// ============================================================================
package board_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STALL  = 2'd1,
        ACCEPT = 2'd2
    } state_t;

    localparam int WORD_BYTES  = 4;
    localparam int SQUARES     = 64;
    localparam int BOARD_WORDS = 64;

    // Square encodings stored one per word
    localparam logic signed [31:0] WHITE = 32'sd1;
    localparam logic signed [31:0] BLACK = -32'sd1;
    localparam logic signed [31:0] EMPTY = 32'sd0;

    localparam logic [31:0] ERR_PATTERN = 32'hDEADBEEF;

endpackage
`default_nettype wire

// File: rtl/board_mem_rd_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : board_mem_rd_pipe
//  Description : LATENCY-stage {valid, data} shift register, async reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module board_mem_rd_pipe #(
    parameter int LATENCY = 2,
    parameter int WIDTH   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic [LATENCY-1:0] r_valid;
    logic [WIDTH-1:0]   r_data [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_data[0]  <= i_data;
            for (int i = 1; i < LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign o_valid = r_valid[LATENCY-1];
    assign o_data  = r_data[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/board_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : board_mem_responder
//  Description : Avalon-MM on-chip board memory with programmable waitrequest
//                stall and fixed pipelined read latency.
//                Optional: BOARD_MEM_ERR_EN adds the sticky slave_err flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module board_mem_responder
    import board_mem_pkg::*;
#(
    parameter int WORDS        = 4096,
    parameter int WAIT_CYCLES  = 1,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] slave_address,
    input  logic        slave_read,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    output logic        slave_waitrequest,
    output logic [31:0] slave_readdata,
    output logic        slave_readdatavalid
`ifdef BOARD_MEM_ERR_EN
    ,
    output logic        slave_err
`endif
);

    localparam int AW = $clog2(WORDS);

`ifdef BOARD_MEM_ERR_EN
    localparam logic [31:0] OOR_DATA = ERR_PATTERN;
`else
    localparam logic [31:0] OOR_DATA = 32'h0;
`endif

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [31:0] r_mem [WORDS];

    logic          w_req;
    logic          w_accept;
    logic [AW-1:0] w_idx;
    logic          w_oor;
    logic          w_do_write;
    logic          w_do_read;
    logic [31:0]   w_rd_data;
    logic          w_unused_addr_lsbs;

    assign w_req              = slave_read | slave_write;
    assign w_accept           = (r_state == ACCEPT);
    assign w_idx              = slave_address[AW+1:2];
    assign w_unused_addr_lsbs = ^slave_address[1:0];

    // Any set bit above the word index, or an index past the end, is out of range
    assign w_oor = (|slave_address[31:AW+2]) ||
                   ({{(32-AW){1'b0}}, w_idx} >= 32'(WORDS));

    assign w_do_write = w_accept & slave_write & ~w_oor;
    assign w_do_read  = w_accept & slave_read & ~slave_write;
    assign w_rd_data  = w_oor ? OOR_DATA : r_mem[w_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_cnt_next   = 4'(WAIT_CYCLES);
                    w_state_next = (WAIT_CYCLES > 0) ? STALL : ACCEPT;
                end
            end
            STALL: begin
                if (!w_req) begin
                    w_state_next = IDLE;
                    w_cnt_next   = 4'd0;
                end else if (r_cnt <= 4'd1) begin
                    w_state_next = ACCEPT;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ACCEPT: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    assign slave_waitrequest = ~w_accept;

    // Storage is deliberately left out of reset so it behaves like real memory
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[w_idx] <= slave_writedata;
        end
    end

    board_mem_rd_pipe #(
        .LATENCY (READ_LATENCY),
        .WIDTH   (32)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_do_read),
        .i_data  (w_rd_data),
        .o_valid (slave_readdatavalid),
        .o_data  (slave_readdata)
    );

`ifdef BOARD_MEM_ERR_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept && ((w_oor && w_req) || (slave_read && slave_write))) begin
            r_err <= 1'b1;
        end
    end

    assign slave_err = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_board_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_mem_responder
//  Description : Self-checking bench: two responder instances (1/2 and 3/4
//                wait/latency) against a behavioural memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_board_mem_responder;

    localparam int          WORDS    = 4096;
    localparam logic [31:0] OOR_BASE = 32'(4 * WORDS);
`ifdef BOARD_MEM_ERR_EN
    localparam logic [31:0] OOR_VAL  = 32'hDEADBEEF;
`else
    localparam logic [31:0] OOR_VAL  = 32'h0;
`endif

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1, rst_b = 1'b1;
    logic        rd_a = 1'b0, wr_a = 1'b0, rd_b = 1'b0, wr_b = 1'b0;
    logic [31:0] addr_a = '0, wdata_a = '0, addr_b = '0, wdata_b = '0;
    logic        wreq_a, wreq_b, rdv_a, rdv_b;
    logic [31:0] rdata_a, rdata_b;
`ifdef BOARD_MEM_ERR_EN
    logic        err_a, err_b;
`endif

    int cyc = 0;
    int passed = 0;
    int total = 0;

    logic [31:0] mdl_a [int];
    logic [31:0] mdl_b [int];
    rec_t exp_a[$], exp_b[$], rx_a[$], rx_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    board_mem_responder #(.WORDS(WORDS), .WAIT_CYCLES(1), .READ_LATENCY(2)) dut_a (
        .clk                 (clk),
        .rst                 (rst_a),
        .slave_address       (addr_a),
        .slave_read          (rd_a),
        .slave_write         (wr_a),
        .slave_writedata     (wdata_a),
        .slave_waitrequest   (wreq_a),
        .slave_readdata      (rdata_a),
        .slave_readdatavalid (rdv_a)
`ifdef BOARD_MEM_ERR_EN
        ,
        .slave_err           (err_a)
`endif
    );

    board_mem_responder #(.WORDS(WORDS), .WAIT_CYCLES(3), .READ_LATENCY(4)) dut_b (
        .clk                 (clk),
        .rst                 (rst_b),
        .slave_address       (addr_b),
        .slave_read          (rd_b),
        .slave_write         (wr_b),
        .slave_writedata     (wdata_b),
        .slave_waitrequest   (wreq_b),
        .slave_readdata      (rdata_b),
        .slave_readdatavalid (rdv_b)
`ifdef BOARD_MEM_ERR_EN
        ,
        .slave_err           (err_b)
`endif
    );

    // Read-return monitors, sampled mid-cycle
    always @(negedge clk) begin
        rec_t r;
        if (rdv_a === 1'b1) begin
            r.data = rdata_a; r.cyc = cyc; rx_a.push_back(r);
        end
        if (rdv_b === 1'b1) begin
            r.data = rdata_b; r.cyc = cyc; rx_b.push_back(r);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic wreq(input int d);
        return (d == 0) ? wreq_a : wreq_b;
    endfunction

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic drive(input int d, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] data);
        if (d == 0) begin
            rd_a = rd; wr_a = wr; addr_a = addr; wdata_a = data;
        end else begin
            rd_b = rd; wr_b = wr; addr_b = addr; wdata_b = data;
        end
    endtask

    // One master transaction; returns the cycle in which it was accepted
    task automatic bus(input int d, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] data, output int acc);
        int   n;
        rec_t e;
        drive(d, rd, wr, addr, data);
        n = 0;
        while (wreq(d) !== 1'b0 && n < 64) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 64) begin
            chk("accept_timeout", {31'b0, wreq(d)}, 32'h0);
            acc = -1;
        end else begin
            acc = cyc;
            @(posedge clk); #1;
        end
        drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
        if (acc >= 0) begin
            if (wr) begin
                if (addr < OOR_BASE) begin
                    if (d == 0) mdl_a[int'(addr >> 2)] = data;
                    else        mdl_b[int'(addr >> 2)] = data;
                end
            end else if (rd) begin
                if (addr >= OOR_BASE)  e.data = OOR_VAL;
                else if (d == 0)       e.data = mdl_a[int'(addr >> 2)];
                else                   e.data = mdl_b[int'(addr >> 2)];
                e.cyc = acc + lat(d);
                if (d == 0) exp_a.push_back(e);
                else        exp_b.push_back(e);
            end
        end
    endtask

    task automatic drain(input int d);
        rec_t e, r;
        repeat (lat(d) + 2) @(posedge clk);
        #1;
        if (d == 0) begin
            while (exp_a.size() > 0) begin
                e = exp_a.pop_front();
                if (rx_a.size() > 0) r = rx_a.pop_front();
                else begin r.data = 'x; r.cyc = -1; end
                chk("rd_data_a", r.data, e.data);
                chk("rd_cycle_a", 32'(r.cyc), 32'(e.cyc));
            end
            chk("extra_valid_a", 32'(rx_a.size()), 32'h0);
            rx_a.delete();
        end else begin
            while (exp_b.size() > 0) begin
                e = exp_b.pop_front();
                if (rx_b.size() > 0) r = rx_b.pop_front();
                else begin r.data = 'x; r.cyc = -1; end
                chk("rd_data_b", r.data, e.data);
                chk("rd_cycle_b", 32'(r.cyc), 32'(e.cyc));
            end
            chk("extra_valid_b", 32'(rx_b.size()), 32'h0);
            rx_b.delete();
        end
    endtask

    initial begin
        int          c0, acc, first_acc, base, op, k;
        int          widx[$];
        logic [31:0] v, a;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wait_a", {31'b0, wreq_a}, 32'h1);
        chk("rst_rdv_a", {31'b0, rdv_a}, 32'h0);
        chk("rst_rdata_a", rdata_a, 32'h0);
        chk("rst_wait_b", {31'b0, wreq_b}, 32'h1);
`ifdef BOARD_MEM_ERR_EN
        chk("rst_err_a", {31'b0, err_a}, 32'h0);
`endif
        rst_a = 1'b0; rst_b = 1'b0;
        @(posedge clk); #1;

        // Basic write then read at 0x104
        c0 = cyc; bus(0, 1'b0, 1'b1, 32'h104, 32'h5, acc);
        chk("wait_wr_a", 32'(acc - c0), 32'd2);
        c0 = cyc; bus(0, 1'b1, 1'b0, 32'h104, 32'h0, acc);
        chk("wait_rd_a", 32'(acc - c0), 32'd2);
        drain(0);

        // Board preload and back-to-back fetch
        base = 64 * $urandom_range(0, 63);
        for (int i = 0; i < 64; i++) begin
            bus(0, 1'b0, 1'b1, 32'((base + i) * 4), $urandom, acc);
            widx.push_back(base + i);
        end
        first_acc = 0;
        for (int i = 0; i < 64; i++) begin
            bus(0, 1'b1, 1'b0, 32'((base + i) * 4), 32'h0, acc);
            if (i == 0) first_acc = acc;
        end
        chk("fetch_period", 32'(acc - first_acc), 32'(63 * 3));
        drain(0);

        // Out-of-range write must not alias onto word 0
        v = $urandom;
        bus(0, 1'b0, 1'b1, 32'h0, v, acc);
        widx.push_back(0);
`ifdef BOARD_MEM_ERR_EN
        chk("err_before_oor_a", {31'b0, err_a}, 32'h0);
`endif
        bus(0, 1'b0, 1'b1, OOR_BASE, 32'h7, acc);
        bus(0, 1'b1, 1'b0, OOR_BASE, 32'h0, acc);
        bus(0, 1'b1, 1'b0, 32'h0, 32'h0, acc);
        drain(0);
`ifdef BOARD_MEM_ERR_EN
        chk("err_after_oor_a", {31'b0, err_a}, 32'h1);
`endif

        // Randomised mix of in-range / out-of-range traffic
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    k = $urandom_range(0, WORDS - 1);
                    widx.push_back(k);
                    bus(0, 1'b0, 1'b1, 32'(k * 4) | 32'($urandom_range(0, 3)), $urandom, acc);
                end
                1: begin
                    a = OOR_BASE + 32'($urandom_range(0, 100000));
                    bus(0, 1'b0, 1'b1, a, $urandom, acc);
                end
                2: begin
                    k = widx[$urandom_range(0, widx.size() - 1)];
                    bus(0, 1'b1, 1'b0, 32'(k * 4) | 32'($urandom_range(0, 3)), 32'h0, acc);
                end
                default: begin
                    a = ($urandom_range(0, 1) == 0) ? (OOR_BASE | $urandom) : (32'h8000_0000 | $urandom);
                    bus(0, 1'b1, 1'b0, a, 32'h0, acc);
                end
            endcase
        end
        drain(0);

        // Stall timing on the 3-wait / 4-latency instance
        v = $urandom | 32'h1;
        c0 = cyc; bus(1, 1'b0, 1'b1, 32'h40, v, acc);
        chk("wait_stall_b", 32'(acc - c0), 32'd4);
        chk("wait_high_after_b", {31'b0, wreq_b}, 32'h1);
        bus(1, 1'b1, 1'b0, 32'h40, 32'h0, acc);
        drain(1);

        // Request dropped mid-stall: no access
        drive(1, 1'b1, 1'b0, 32'h40, 32'h0);
        repeat (2) begin @(posedge clk); #1; end
        chk("drop_wait_b", {31'b0, wreq_b}, 32'h1);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        chk("drop_no_valid_b", 32'(rx_b.size()), 32'h0);

        // Reset one cycle after an accepted read
        bus(1, 1'b1, 1'b0, 32'h40, 32'h0, acc);
        rst_b = 1'b1;
        #1;
        chk("rst_mid_rdv_b", {31'b0, rdv_b}, 32'h0);
        chk("rst_mid_wait_b", {31'b0, wreq_b}, 32'h1);
        chk("rst_mid_rdata_b", rdata_b, 32'h0);
        @(posedge clk); #1;
        rst_b = 1'b0;
        exp_b.delete();
        repeat (8) @(posedge clk);
        #1;
        chk("rst_mid_no_valid_b", 32'(rx_b.size()), 32'h0);
        bus(1, 1'b1, 1'b0, 32'h40, 32'h0, acc);
        drain(1);

        // Simultaneous read + write: write wins, no read return
`ifdef BOARD_MEM_ERR_EN
        chk("err_before_rw_b", {31'b0, err_b}, 32'h0);
`endif
        bus(1, 1'b1, 1'b1, 32'h0, 32'h9, acc);
        drain(1);
`ifdef BOARD_MEM_ERR_EN
        chk("err_after_rw_b", {31'b0, err_b}, 32'h1);
`endif
        bus(1, 1'b1, 1'b0, 32'h0, 32'h0, acc);
        drain(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
